pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 125 ++++++++++++
 tb/tb_pc_stack.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter with an edge-qualified call/return stack.
// Supplies the next fetch address and records return addresses for nested calls.
module pc_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     rst,
  input  logic                     hlt,
  input  logic                     wrpc,
  input  logic                     jump,
  input  logic                     prefix,
  input  logic                     ch,
  input  logic                     ret,
  input  logic [W-1:0]             alu_y,
  input  logic [W-1:0]             reg_a,
  input  logic [W-1:0]             imm,
  output logic [W-1:0]             pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_JMP,
    PC_RET
  } pc_src_e;

  logic [W-1:0]    stack [DEPTH];
  logic [W-1:0]    ret_tgt;
  logic            ch_d;
  logic            ret_d;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            stack_we;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   top_idx;
  pc_src_e         pc_src;
  logic [W-1:0]    pc_next;

  // Strobes from the control unit may stay high for several cycles; act on the rising edge only.
  assign push  = ch & ~ch_d;
  assign pop   = ret & ~ret_d;
  assign full  = (depth == FULL);
  assign empty = (depth == '0);

  assign wr_idx  = depth[AW-1:0];
  assign top_idx = AW'(depth - DW'(1));

  // A simultaneous push and pop cancels out, so only a lone push writes memory.
  assign stack_we = ~init & ~hlt & ~rst & push & ~pop & ~full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pc_src = PC_HOLD;
    if (wrpc) begin
      if (!jump)    pc_src = PC_SEQ;
      else if (ret) pc_src = PC_RET;
      else          pc_src = PC_JMP;
    end
  end

  always_comb begin
    pc_next = pc;
    unique case (pc_src)
      PC_SEQ:  pc_next = alu_y;
      PC_JMP:  pc_next = prefix ? imm : reg_a;
      PC_RET:  pc_next = ret_tgt;
      default: pc_next = pc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (init) begin
      pc      <= '0;
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      ret_tgt <= '0;
      ch_d    <= 1'b0;
      ret_d   <= 1'b0;
    end else if (!hlt) begin
      ch_d  <= ch;
      ret_d <= ret;
      if (rst) begin
        pc      <= '0;
        depth   <= '0;
        stk_ovf <= 1'b0;
        stk_unf <= 1'b0;
      end else begin
        pc <= pc_next;
        if (push && pop) begin
          ret_tgt <= pc;
        end else if (push) begin
          if (full) stk_ovf <= 1'b1;
          else      depth   <= depth + DW'(1);
        end else if (pop) begin
          if (empty) begin
            ret_tgt <= pc;
            stk_unf <= 1'b1;
          end else begin
            ret_tgt <= stack[top_idx];
            depth   <= depth - DW'(1);
          end
        end
      end
    end
  end

  // NOTE: stack storage has no reset; entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (stack_we) stack[wr_idx] <= pc;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: the driver queues hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_stack;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          init, rst, hlt, wrpc, jump, prefix, ch, ret;
  logic [W-1:0]  alu_y, reg_a, imm;
  logic [W-1:0]  pc;
  logic [DW-1:0] depth;
  logic          stk_ovf, stk_unf;

  typedef struct {
    string         name;
    logic [W-1:0]  pc;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_stack #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .init(init), .rst(rst), .hlt(hlt), .wrpc(wrpc), .jump(jump),
    .prefix(prefix), .ch(ch), .ret(ret), .alu_y(alu_y), .reg_a(reg_a), .imm(imm),
    .pc(pc), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: outputs are settled by the falling edge after each driven cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".pc"},    32'(pc),      32'(e.pc));
        check({e.name, ".depth"}, 32'(depth),   32'(e.depth));
        check({e.name, ".ovf"},   32'(stk_ovf), 32'(e.ovf));
        check({e.name, ".unf"},   32'(stk_unf), 32'(e.unf));
      end
    end
  end

  task automatic idle();
    init = 0; rst = 0; hlt = 0; wrpc = 0; jump = 0; prefix = 0; ch = 0; ret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string name, input logic [W-1:0] p, input int d,
                           input logic o, input logic u);
    exp_t e;
    e.name = name; e.pc = p; e.depth = DW'(d); e.ovf = o; e.unf = u;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    alu_y = '0; reg_a = '0; imm = '0;
    #1;

    // Reset state
    init = 1; tick(); tick();
    expect_st("reset", 16'h0000, 0, 0, 0);
    init = 0;

    // Sequential fetch and hold
    wrpc = 1; alu_y = 16'h0002; tick();
    expect_st("seq", 16'h0002, 0, 0, 0);
    wrpc = 0; alu_y = 16'h1234; tick();
    expect_st("hold", 16'h0002, 0, 0, 0);

    // Call / jump / return with long strobes
    wrpc = 1; alu_y = 16'h0010; tick();
    expect_st("set10", 16'h0010, 0, 0, 0);
    wrpc = 0; ch = 1; tick();
    expect_st("call1", 16'h0010, 1, 0, 0);
    tick();
    expect_st("call_held", 16'h0010, 1, 0, 0);
    ch = 0; jump = 1; prefix = 1; imm = 16'h0100; wrpc = 1; tick();
    expect_st("jmp_imm", 16'h0100, 1, 0, 0);
    idle(); ret = 1; tick();
    expect_st("ret_c1", 16'h0100, 0, 0, 0);
    wrpc = 1; jump = 1; tick();
    expect_st("ret_c2", 16'h0010, 0, 0, 0);
    wrpc = 0; jump = 0; tick();
    expect_st("ret_c3", 16'h0010, 0, 0, 0);
    idle(); tick();

    // Register jump target and full-width wrap value
    wrpc = 1; jump = 1; prefix = 0; reg_a = 16'h0ABC; imm = 16'h0DEF; tick();
    expect_st("jmp_reg", 16'h0ABC, 0, 0, 0);
    jump = 0; alu_y = 16'hFFFF; tick();
    expect_st("seq_ffff", 16'hFFFF, 0, 0, 0);
    idle();

    // Overflow: nine pushes, each alongside a PC update (push uses the old pc)
    init = 1; tick(); init = 0;
    wrpc = 1; alu_y = 16'h0001; tick();
    for (int i = 1; i <= 9; i++) begin
      ch = 1; wrpc = 1; alu_y = W'(i + 1); tick();
      expect_st($sformatf("push%0d", i), W'(i + 1), (i > 8) ? 8 : i, i == 9, 0);
      ch = 0; wrpc = 0; tick();
    end
    for (int k = 8; k >= 1; k--) begin
      idle(); ret = 1; tick();
      expect_st($sformatf("pop%0d", k), (k == 8) ? 16'h000A : W'(k + 1), k - 1, 1, 0);
      wrpc = 1; jump = 1; tick();
      expect_st($sformatf("retpc%0d", k), W'(k), k - 1, 1, 0);
      idle(); tick();
    end

    // Underflow, with init during a held call strobe
    ch = 1; init = 1; tick();
    expect_st("init_abort", 16'h0000, 0, 0, 0);
    idle(); tick();
    wrpc = 1; alu_y = 16'h0040; tick();
    expect_st("set40", 16'h0040, 0, 0, 0);
    wrpc = 0; ret = 1; tick();
    expect_st("unf_pop", 16'h0040, 0, 0, 1);
    wrpc = 1; jump = 1; tick();
    expect_st("unf_ret", 16'h0040, 0, 0, 1);
    idle(); tick();

    // Halt freezes everything, then soft reset
    ch = 1; tick();
    expect_st("pre_hlt_push", 16'h0040, 1, 0, 1);
    ch = 0; tick();
    hlt = 1; wrpc = 1; alu_y = 16'h0555; ch = 1; ret = 1; tick();
    expect_st("hlt1", 16'h0040, 1, 0, 1);
    tick();
    expect_st("hlt2", 16'h0040, 1, 0, 1);
    hlt = 0; ch = 0; ret = 0; rst = 1; tick();
    expect_st("soft_rst", 16'h0000, 0, 0, 0);
    idle(); tick();

    // Simultaneous push+pop at depth 3
    wrpc = 1; alu_y = 16'h0011; tick();
    ch = 1; alu_y = 16'h0012; tick();
    ch = 0; wrpc = 0; tick();
    ch = 1; wrpc = 1; alu_y = 16'h0013; tick();
    ch = 0; wrpc = 0; tick();
    ch = 1; wrpc = 1; alu_y = 16'h0022; tick();
    ch = 0; wrpc = 0; tick();
    expect_st("depth3", 16'h0022, 3, 0, 0);
    ch = 1; ret = 1; tick();
    expect_st("push_pop", 16'h0022, 3, 0, 0);
    ch = 0; wrpc = 1; jump = 0; alu_y = 16'h0077; tick();
    expect_st("set77", 16'h0077, 3, 0, 0);
    jump = 1; tick();
    expect_st("pp_tgt", 16'h0022, 3, 0, 0);
    idle(); tick();
    ret = 1; tick();
    expect_st("pop_after_pp", 16'h0022, 2, 0, 0);
    wrpc = 1; jump = 1; tick();
    expect_st("ret_13", 16'h0013, 2, 0, 0);
    idle();

    // init with a pending return clears everything
    ret = 1; init = 1; tick();
    expect_st("final_init", 16'h0000, 0, 0, 0);
    idle(); tick();

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
